// File: rtl/cpu19_pkg.sv
// Shared definitions for the 19-bit CPU output path: word geometry, UART
// serializer state encoding and the per-word byte selection rule.
package cpu19_pkg;

    localparam int WORD_W     = 19;
    localparam int UART_BYTES = 3;
    localparam int LEVEL_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // Byte idx of a word as it goes on the wire; the top byte carries W[18:16].
    function automatic logic [7:0] wordByte(input logic [WORD_W-1:0] w,
                                            input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            default: return {5'b00000, w[18:16]};
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_19bit.sv
// Small synchronous FIFO: storage, wrapping pointers and an explicit level
// count so full and empty never alias. Pop has priority in freeing a slot,
// so a push into a full FIFO succeeds when a pop lands on the same edge.
module sync_fifo_19bit
    import cpu19_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wrData,
    output logic [WIDTH-1:0]   rdData,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (level == LEVEL_W'(DEPTH));
    assign doPop  = pop && (level != '0);
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            level <= level + LEVEL_W'(doPush) - LEVEL_W'(doPop);
        end
    end

endmodule

// File: rtl/regf_uart_tx.sv
// RegF output stage: captures every word loaded into RegF, buffers it and
// sends it as three 8N1 bytes (low byte first) on TX. TX and BUSY are
// registered from the current state, so the line lags the FSM by one cycle.
module regf_uart_tx
    import cpu19_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [WORD_W-1:0] WR_DATA,
    input  logic              WR_EN,
    input  logic              OVF_CLR,
    output logic              TX,
    output logic              BUSY,
    output logic              FULL,
    output logic [4:0]        LEVEL,
    output logic              OVF
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    txState_t          state;
    logic [CNT_W-1:0]  baudCnt;
    logic [2:0]        bitIdx;
    logic [1:0]        byteIdx;
    logic [WORD_W-1:0] shiftWord;
    logic [WORD_W-1:0] headWord;
    logic [7:0]        curByte;
    logic              pop;
    logic              drop;
    logic              baudWrap;

    // A pop only happens from IDLE with data present; never a same-cycle bypass.
    assign pop      = (state == IDLE) && (LEVEL != '0);
    assign drop     = WR_EN && FULL && !pop;
    assign baudWrap = (baudCnt == CNT_W'(CLKS_PER_BIT - 1));
    assign curByte  = wordByte(shiftWord, byteIdx);

    sync_fifo_19bit #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk    (CLK),
        .rst    (CLR),
        .push   (WR_EN),
        .pop    (pop),
        .wrData (WR_DATA),
        .rdData (headWord),
        .full   (FULL),
        .level  (LEVEL)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)          OVF <= 1'b0;
        else if (drop)    OVF <= 1'b1;
        else if (OVF_CLR) OVF <= 1'b0;
    end

    // Serializer FSM with baud counter and registered line outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            byteIdx   <= '0;
            shiftWord <= '0;
            TX        <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            BUSY <= (state != IDLE);
            case (state)
                START:   TX <= 1'b0;
                DATA:    TX <= curByte[bitIdx];
                default: TX <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baudCnt <= '0;
                    if (pop) begin
                        shiftWord <= headWord;
                        byteIdx   <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (baudWrap) begin
                        baudCnt <= '0;
                        bitIdx  <= '0;
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baudWrap) begin
                        baudCnt <= '0;
                        if (bitIdx == 3'd7) state <= STOP;
                        else                bitIdx <= bitIdx + 3'd1;
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baudWrap) begin
                        baudCnt <= '0;
                        if (byteIdx < 2'(UART_BYTES - 1)) begin
                            byteIdx <= byteIdx + 2'd1;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baudCnt <= baudCnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regf_uart_tx.sv
// Bench for regf_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. A word-level model
// (queue + frame timer + 30-bit frame image) predicts TX/BUSY/LEVEL/FULL/OVF on
// every cycle; directed scenarios add literal checks decoded from the TX log.
module tb_regf_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 30 * CPB;

    logic        CLK, CLR, WR_EN, OVF_CLR;
    logic [18:0] WR_DATA;
    logic        TX, BUSY, FULL, OVF;
    logic [4:0]  LEVEL;

    regf_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .CLR(CLR), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .OVF_CLR(OVF_CLR),
        .TX(TX), .BUSY(BUSY), .FULL(FULL), .LEVEL(LEVEL), .OVF(OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    bit chkOn  = 0;
    logic txLog   [0:4095];
    logic busyLog [0:4095];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    logic [18:0] q [$];
    int          ph;
    logic [29:0] fr;
    logic        expTx, expBusy, expOvf, expFull;
    int          expLevel;

    initial begin
        ph = 1000; fr = '1; expTx = 1; expBusy = 0; expOvf = 0; expFull = 0; expLevel = 0;
        forever begin
            @(posedge CLK or posedge CLR);
            if (CLR) begin
                q.delete(); ph = 1000; expOvf = 0;
            end else begin
                bit popNow, pushNow;
                logic [18:0] wd;
                logic [7:0]  bt;
                cyc++;
                if (ph < 1000) ph++;
                popNow  = (ph >= FRAME + 1) && (q.size() > 0);
                pushNow = WR_EN && ((q.size() < DEPTH) || popNow);
                if (popNow) begin
                    wd = q.pop_front();
                    for (int b = 0; b < 3; b++) begin
                        bt = (b == 0) ? wd[7:0] : (b == 1) ? wd[15:8] : {5'b0, wd[18:16]};
                        fr[10*b] = 1'b0;
                        for (int i = 0; i < 8; i++) fr[10*b+1+i] = bt[i];
                        fr[10*b+9] = 1'b1;
                    end
                    ph = 0;
                end
                if (pushNow) q.push_back(WR_DATA);
                if (WR_EN && !pushNow) expOvf = 1;
                else if (OVF_CLR)      expOvf = 0;
            end
            expTx    = (ph >= 1 && ph <= FRAME) ? fr[(ph-1)/CPB] : 1'b1;
            expBusy  = (ph >= 1 && ph <= FRAME);
            expLevel = q.size();
            expFull  = (q.size() == DEPTH);
        end
    end

    // Per-cycle compare against the model, plus line logging for decoding.
    initial begin
        forever begin
            @(negedge CLK);
            if (!CLR) begin
                txLog[cyc]   = TX;
                busyLog[cyc] = BUSY;
                if (chkOn) begin
                    chk("tx",    32'(TX),    32'(expTx));
                    chk("busy",  32'(BUSY),  32'(expBusy));
                    chk("level", 32'(LEVEL), 32'(expLevel));
                    chk("full",  32'(FULL),  32'(expFull));
                    chk("ovf",   32'(OVF),   32'(expOvf));
                end
            end
        end
    end

    // Decode byte b of a frame whose start bit begins at cycle f, sampling mid-bit.
    function automatic logic [7:0] dec(input int f, input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = txLog[f + CPB*(10*b+1+i) + 2];
        return r;
    endfunction

    task automatic chkFrame(input string nm, input int f, input logic [23:0] expBytes);
        for (int b = 0; b < 3; b++) begin
            chk({nm, "_start"}, 32'(txLog[f + CPB*(10*b) + 2]), 32'd0);
            chk({nm, "_byte"},  32'(dec(f, b)), 32'(expBytes[8*b +: 8]));
            chk({nm, "_stop"},  32'(txLog[f + CPB*(10*b+9) + 2]), 32'd1);
        end
    endtask

    function automatic int busyCount(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) n += int'(busyLog[i]);
        return n;
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    int w, a, o;

    initial begin
        CLR = 1; WR_EN = 0; OVF_CLR = 0; WR_DATA = '0;
        #2;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        repeat (2) tick();
        CLR = 0; chkOn = 1;
        repeat (3) tick();

        // single word
        w = cyc + 1;
        WR_DATA = 19'h5A3C1; WR_EN = 1; tick(); WR_EN = 0;
        chk("sw_level_after_wr", 32'(LEVEL), 32'd1);
        tick();
        chk("sw_level_after_pop", 32'(LEVEL), 32'd0);
        repeat (130) tick();
        chk("sw_tx_hi_1", 32'(txLog[w+1]), 32'd1);
        chk("sw_tx_fall", 32'(txLog[w+2]), 32'd0);
        chk("sw_busy_cnt", 32'(busyCount(w, w + 130)), 32'd120);
        chkFrame("sw", w + 2, 24'h05A3C1);

        // back-to-back words
        a = cyc + 1;
        WR_DATA = 19'h00001; WR_EN = 1; tick();
        WR_DATA = 19'h7FFFF; tick(); WR_EN = 0;
        repeat (260) tick();
        chkFrame("b2b0", a + 2, 24'h000001);
        chk("b2b_stop_end", 32'(txLog[a + 2 + FRAME - 1]), 32'd1);
        chk("b2b_idle_gap", 32'(txLog[a + 2 + FRAME]), 32'd1);
        chk("b2b_gap_busy", 32'(busyLog[a + 2 + FRAME]), 32'd0);
        chk("b2b_next_fall", 32'(txLog[a + 2 + FRAME + 1]), 32'd0);
        chkFrame("b2b1", a + 3 + FRAME, 24'h07FFFF);
        chk("b2b_busy_cnt", 32'(busyCount(a, a + 260)), 32'd240);

        // overflow: six consecutive writes from idle
        o = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            WR_DATA = 19'(19'h11111 * (k + 1)); WR_EN = 1; tick();
        end
        WR_EN = 0;
        chk("ovf_full", 32'(FULL), 32'd1);
        chk("ovf_set", 32'(OVF), 32'd1);
        chk("ovf_level", 32'(LEVEL), 32'd4);
        OVF_CLR = 1; tick(); OVF_CLR = 0;
        chk("ovfclr_ovf", 32'(OVF), 32'd0);
        chk("ovfclr_full", 32'(FULL), 32'd1);

        // drop and clear in the same cycle
        WR_DATA = 19'h6DEAD; WR_EN = 1; OVF_CLR = 1; tick(); WR_EN = 0; OVF_CLR = 0;
        chk("dropclr_ovf", 32'(OVF), 32'd1);
        chk("dropclr_level", 32'(LEVEL), 32'd4);
        OVF_CLR = 1; tick(); OVF_CLR = 0;
        chk("reclr_ovf", 32'(OVF), 32'd0);

        // write on the pop edge while full
        while (cyc < o + FRAME + 1) tick();
        WR_DATA = 19'h2BEEF; WR_EN = 1; tick(); WR_EN = 0;
        chk("fullpop_level", 32'(LEVEL), 32'd4);
        chk("fullpop_ovf", 32'(OVF), 32'd0);
        chk("fullpop_full", 32'(FULL), 32'd1);
        repeat (2) tick();
        chk("fullpop_start_bit", 32'(TX), 32'd0);
        WR_DATA = 19'h00777; WR_EN = 1; tick(); WR_EN = 0;
        chk("predrop_ovf", 32'(OVF), 32'd1);

        // asynchronous reset mid-frame
        #2 CLR = 1;
        #1;
        chk("arst_tx", 32'(TX), 32'd1);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_level", 32'(LEVEL), 32'd0);
        chk("arst_ovf", 32'(OVF), 32'd0);
        chk("arst_full", 32'(FULL), 32'd0);
        repeat (2) tick();
        CLR = 0;
        tick();

        // recovery after reset
        w = cyc + 1;
        WR_DATA = 19'h12345; WR_EN = 1; tick(); WR_EN = 0;
        repeat (130) tick();
        chk("post_fall", 32'(txLog[w+2]), 32'd0);
        chkFrame("post", w + 2, 24'h012345);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
